pool_ctrl: RTL and testbench

POOL_CTRL -- requirements
Module: pool_ctrl

---
 rtl/pool_ctrl.sv | 168 ++++++++++++++++
 tb/tb_pool_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pool_ctrl.sv
// 2x2 max-pool sequencer: walks an IMG_W x IMG_H map, drives line/output buffer addresses and strobes.
// Optional abort input enabled by defining POOL_CTRL_ABORT_EN.
module pool_ctrl #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned IMG_W  = 8,
    parameter int unsigned IMG_H  = 8
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start,
    input  logic              stall,
    input  logic              in_valid,
`ifdef POOL_CTRL_ABORT_EN
    input  logic              abort,
`endif
    output logic              in_ready,
    output logic [ADDR_W-1:0] adrs,
    output logic [ADDR_W-1:0] adrs_out,
    output logic              mux_en,
    output logic              wr_ctrl1,
    output logic              wr_ctrl2,
    output logic              pool_done,
    output logic              busy
);

    localparam int unsigned CW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
    localparam int unsigned RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ROW_A = 2'd1;
    localparam logic [1:0] S_ROW_B = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state, state_nx;
    logic [CW-1:0]     col, col_nx;
    logic [RW-1:0]     row, row_nx;
    logic [ADDR_W-1:0] adrs_nx, adrs_out_nx;
    logic              mux_en_nx, wr1_nx, wr2_nx, done_nx, busy_nx;
    logic              inc_pend, inc_pend_nx;
    logic              abort_hit;
    logic              in_row;
    logic              beat;

`ifdef POOL_CTRL_ABORT_EN
    assign abort_hit = abort && (state != S_IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    assign in_row   = (state == S_ROW_A) || (state == S_ROW_B);
    assign in_ready = in_row && !stall && !abort_hit;
    assign beat     = in_valid && in_ready;

    // State register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state, counter and output-register next values
    always_comb begin
        state_nx    = state;
        col_nx      = col;
        row_nx      = row;
        adrs_nx     = adrs;
        adrs_out_nx = adrs_out;
        mux_en_nx   = mux_en;
        wr1_nx      = 1'b0;
        wr2_nx      = 1'b0;
        done_nx     = 1'b0;
        inc_pend_nx = inc_pend;

        // adrs_out advances after each output write; the bump waits out a stall
        if (wr_ctrl2 || inc_pend) begin
            if (stall) begin
                inc_pend_nx = 1'b1;
            end else begin
                adrs_out_nx = adrs_out + ADDR_W'(1);
                inc_pend_nx = 1'b0;
            end
        end

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx    = S_ROW_A;
                    col_nx      = '0;
                    row_nx      = '0;
                    adrs_out_nx = '0;
                    inc_pend_nx = 1'b0;
                end
            end
            S_ROW_A, S_ROW_B: begin
                if (beat) begin
                    adrs_nx   = ADDR_W'(col >> 1);
                    mux_en_nx = (state == S_ROW_B);
                    wr1_nx    = (state == S_ROW_A) && col[0];
                    wr2_nx    = (state == S_ROW_B) && col[0];
                    if (col == CW'(IMG_W - 1)) begin
                        col_nx = '0;
                        row_nx = row + RW'(1);
                        if (state == S_ROW_A) begin
                            state_nx = S_ROW_B;
                        end else if (row == RW'(IMG_H - 1)) begin
                            state_nx = S_DONE;
                            done_nx  = 1'b1;
                            row_nx   = '0;
                        end else begin
                            state_nx = S_ROW_A;
                        end
                    end else begin
                        col_nx = col + CW'(1);
                    end
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase

        if (abort_hit) begin
            state_nx    = S_IDLE;
            col_nx      = '0;
            row_nx      = '0;
            adrs_out_nx = '0;
            inc_pend_nx = 1'b0;
            wr1_nx      = 1'b0;
            wr2_nx      = 1'b0;
            done_nx     = 1'b0;
        end

        busy_nx = (state_nx != S_IDLE);
    end

    // Counters and registered outputs
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            col       <= '0;
            row       <= '0;
            inc_pend  <= 1'b0;
            adrs      <= '0;
            adrs_out  <= '0;
            mux_en    <= 1'b0;
            wr_ctrl1  <= 1'b0;
            wr_ctrl2  <= 1'b0;
            pool_done <= 1'b0;
            busy      <= 1'b0;
        end else begin
            col       <= col_nx;
            row       <= row_nx;
            inc_pend  <= inc_pend_nx;
            adrs      <= adrs_nx;
            adrs_out  <= adrs_out_nx;
            mux_en    <= mux_en_nx;
            wr_ctrl1  <= wr1_nx;
            wr_ctrl2  <= wr2_nx;
            pool_done <= done_nx;
            busy      <= busy_nx;
        end
    end

endmodule

// File: tb/tb_pool_ctrl.sv
// Directed bench for pool_ctrl: 4x4 map instance plus an 8x4 map instance with 2-bit addresses.
// Abort scenario included when POOL_CTRL_ABORT_EN is defined.
module tb_pool_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic nrst, start, start2, stall, in_valid, abort;

    logic       in_ready, mux_en, wr_ctrl1, wr_ctrl2, pool_done, busy;
    logic [3:0] adrs, adrs_out;
    logic       in_ready2, mux_en2, wr_ctrl1_2, wr_ctrl2_2, pool_done2, busy2;
    logic [1:0] adrs2, adrs_out2;

    logic [13:0] outs;
    assign outs = {in_ready, busy, wr_ctrl1, wr_ctrl2, pool_done, mux_en, adrs, adrs_out};

    int checks = 0;
    int errors = 0;

    pool_ctrl #(.ADDR_W(4), .IMG_W(4), .IMG_H(4)) dut (
        .clk(clk), .nrst(nrst), .start(start), .stall(stall), .in_valid(in_valid),
`ifdef POOL_CTRL_ABORT_EN
        .abort(abort),
`endif
        .in_ready(in_ready), .adrs(adrs), .adrs_out(adrs_out), .mux_en(mux_en),
        .wr_ctrl1(wr_ctrl1), .wr_ctrl2(wr_ctrl2), .pool_done(pool_done), .busy(busy)
    );

    pool_ctrl #(.ADDR_W(2), .IMG_W(8), .IMG_H(4)) dut2 (
        .clk(clk), .nrst(nrst), .start(start2), .stall(stall), .in_valid(in_valid),
`ifdef POOL_CTRL_ABORT_EN
        .abort(abort),
`endif
        .in_ready(in_ready2), .adrs(adrs2), .adrs_out(adrs_out2), .mux_en(mux_en2),
        .wr_ctrl1(wr_ctrl1_2), .wr_ctrl2(wr_ctrl2_2), .pool_done(pool_done2), .busy(busy2)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        nrst = 1'b0; start = 1'b0; start2 = 1'b0; stall = 1'b0; in_valid = 1'b0; abort = 1'b0;
        #2;
        checks++;
        if (outs !== 14'h0) begin
            errors++;
            $display("FAIL reset_outs got %h exp 0000", outs);
        end
        tick;
        tick;
        nrst = 1'b1;
        tick;
        checks++;
        if ({busy, in_ready, busy2} !== 3'b000) begin
            errors++;
            $display("FAIL reset_idle got %b exp 000", {busy, in_ready, busy2});
        end
    endtask

    // Full 4x4 pass with in_valid held high
    task automatic test_basic(input string tag);
        int beats;
        int r, c;
        logic [7:0] exp_v, obs_v;
        in_valid = 1'b1;
        start = 1'b1;
        tick;
        start = 1'b0;
        checks++;
        if ({busy, in_ready} !== 2'b11) begin
            errors++;
            $display("FAIL %s_enter got %b exp 11", tag, {busy, in_ready});
        end
        beats = 0;
        for (int i = 0; i < 16; i++) begin
            if (in_ready && in_valid) beats++;
            tick;
            r = i / 4;
            c = i % 4;
            exp_v = {(r % 2 == 0) && (c % 2 == 1), (r % 2 == 1) && (c % 2 == 1),
                     4'(c / 2), (r % 2 == 1), (i == 15)};
            obs_v = {wr_ctrl1, wr_ctrl2, adrs, mux_en, pool_done};
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL %s_beat%0d got %b exp %b", tag, i, obs_v, exp_v);
            end
            if ((r % 2 == 1) && (c % 2 == 1)) begin
                checks++;
                if (adrs_out !== 4'((r / 2) * 2 + c / 2)) begin
                    errors++;
                    $display("FAIL %s_adrs_out%0d got %0d exp %0d", tag, i, adrs_out, (r / 2) * 2 + c / 2);
                end
            end
        end
        checks++;
        if (beats != 16 || in_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_done_cycle got beats=%0d rdy=%b busy=%b exp 16 0 1", tag, beats, in_ready, busy);
        end
        tick;
        checks++;
        if ({busy, pool_done, wr_ctrl2} !== 3'b000) begin
            errors++;
            $display("FAIL %s_idle got %b exp 000", tag, {busy, pool_done, wr_ctrl2});
        end
        in_valid = 1'b0;
        tick;
    endtask

    task automatic test_stall;
        int pulses;
        int dones;
        in_valid = 1'b1;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 0; i < 6; i++) tick;
        checks++;
        if ({wr_ctrl2, adrs_out} !== {1'b1, 4'd0}) begin
            errors++;
            $display("FAIL stall_pre got %b/%0d exp 1/0", wr_ctrl2, adrs_out);
        end
        stall = 1'b1;
        pulses = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            pulses += int'(wr_ctrl2);
            checks++;
            if ({in_ready, adrs_out} !== {1'b0, 4'd0}) begin
                errors++;
                $display("FAIL stall_cyc%0d got rdy=%b ao=%0d exp 0 0", k, in_ready, adrs_out);
            end
            tick;
        end
        stall = 1'b0;
        #1;
        checks++;
        if (pulses != 1 || in_ready !== 1'b1 || adrs_out !== 4'd0 || wr_ctrl2 !== 1'b0) begin
            errors++;
            $display("FAIL stall_resume got p=%0d rdy=%b ao=%0d w2=%b exp 1 1 0 0", pulses, in_ready, adrs_out, wr_ctrl2);
        end
        tick;
        checks++;
        if (adrs_out !== 4'd1) begin
            errors++;
            $display("FAIL stall_bump got %0d exp 1", adrs_out);
        end
        dones = 0;
        for (int i = 7; i < 16; i++) begin
            tick;
            dones += int'(pool_done);
        end
        checks++;
        if (dones != 1 || {pool_done, wr_ctrl2, adrs_out} !== {2'b11, 4'd3}) begin
            errors++;
            $display("FAIL stall_end got d=%0d %b/%0d exp 1 11/3", dones, {pool_done, wr_ctrl2}, adrs_out);
        end
        in_valid = 1'b0;
        tick;
        tick;
    endtask

    task automatic test_start_ignored;
        int beats, dones;
        beats = 0;
        dones = 0;
        in_valid = 1'b1;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (pool_done) dones++;
            start = (c == 2) || pool_done;
            if (in_ready && in_valid) beats++;
            tick;
        end
        start = 1'b0;
        checks++;
        if (beats != 16 || dones != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL start_ignored got beats=%0d dones=%0d busy=%b exp 16 1 0", beats, dones, busy);
        end
        in_valid = 1'b0;
        tick;
    endtask

    task automatic test_reset_mid;
        int dones;
        in_valid = 1'b1;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 0; i < 6; i++) tick;
        checks++;
        if ({busy, mux_en} !== 2'b11) begin
            errors++;
            $display("FAIL rstmid_rowb got %b exp 11", {busy, mux_en});
        end
        #2;
        nrst = 1'b0;
        #1;
        checks++;
        if (outs !== 14'h0) begin
            errors++;
            $display("FAIL rstmid_outs got %h exp 0000", outs);
        end
        tick;
        nrst = 1'b1;
        dones = 0;
        for (int i = 0; i < 4; i++) begin
            tick;
            dones += int'(pool_done);
        end
        checks++;
        if (dones != 0 || {busy, in_ready} !== 2'b00) begin
            errors++;
            $display("FAIL rstmid_idle got d=%0d %b exp 0 00", dones, {busy, in_ready});
        end
        in_valid = 1'b0;
    endtask

    task automatic test_wrap;
        int n;
        logic [1:0] exp_ao;
        n = 0;
        in_valid = 1'b1;
        start2 = 1'b1;
        tick;
        start2 = 1'b0;
        for (int i = 0; i < 32; i++) begin
            tick;
            if (wr_ctrl2_2) begin
                exp_ao = 2'(n % 4);
                checks++;
                if (adrs_out2 !== exp_ao) begin
                    errors++;
                    $display("FAIL wrap_ao%0d got %0d exp %0d", n, adrs_out2, exp_ao);
                end
                n++;
            end
        end
        checks++;
        if (n != 8 || {pool_done2, adrs_out2} !== {1'b1, 2'd3}) begin
            errors++;
            $display("FAIL wrap_end got n=%0d d=%b ao=%0d exp 8 1 3", n, pool_done2, adrs_out2);
        end
        in_valid = 1'b0;
        tick;
        tick;
    endtask

`ifdef POOL_CTRL_ABORT_EN
    task automatic test_abort;
        int dones;
        in_valid = 1'b1;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 0; i < 9; i++) tick;
        abort = 1'b1;
        tick;
        abort = 1'b0;
        checks++;
        if ({busy, in_ready, wr_ctrl1, wr_ctrl2, pool_done} !== 5'b0) begin
            errors++;
            $display("FAIL abort_idle got %b exp 00000", {busy, in_ready, wr_ctrl1, wr_ctrl2, pool_done});
        end
        dones = 0;
        for (int i = 0; i < 3; i++) begin
            tick;
            dones += int'(pool_done);
        end
        checks++;
        if (dones != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_nodone got d=%0d busy=%b exp 0 0", dones, busy);
        end
        in_valid = 1'b0;
        tick;
        test_basic("post_abort");
    endtask
`endif

    initial begin
        test_reset();
        test_basic("basic");
        test_stall();
        test_start_ignored();
        test_reset_mid();
        test_basic("post_reset");
        test_wrap();
`ifdef POOL_CTRL_ABORT_EN
        test_abort();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
